// File: rtl/div_tick_sync.sv
`default_nettype none
// ============================================================================
//  Module      : div_tick_sync
//  Description : Synchronises ripple-divider taps into the clk domain, selects
//                one tap at run time and emits a one-cycle tick enable per
//                rising edge of that tap. Also keeps a wrapping tick counter
//                and blanks ticks for a settle window after enable or after
//                a change of tap selection.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_tick_sync #(
    parameter int NTAP       = 10,
    parameter int SEL_W      = 4,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NTAP-1:0]  div_in,
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    input  logic             clr,
    output logic             tick,
    output logic [CNT_W-1:0] tick_cnt,
    output logic             wrap,
    output logic             sel_err,
    output logic             busy
);

    localparam int               c_STW         = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [c_STW-1:0] c_SETTLE_LOAD = c_STW'(SETTLE_CYC - 1);
    localparam logic [c_STW-1:0] c_SETTLE_ONE  = c_STW'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETTLE = 2'd1;
    localparam logic [1:0] c_RUN    = 2'd2;

    logic [NTAP-1:0]  r_s1;
    logic [NTAP-1:0]  r_s2;
    logic             r_prev;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [SEL_W-1:0] r_sel_q;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [c_STW-1:0] r_settle;
    logic [c_STW-1:0] w_settle_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wrap;
    logic             r_sel_err;
    logic             w_sel_ok;
    logic             w_tap;
    logic             w_rise;

    // Two-flop synchroniser on every tap, running regardless of FSM state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= div_in;
            r_s2 <= r_s1;
        end
    end

    // Tap mux; an out-of-range selection reads as a constant low tap
    always_comb begin
        w_tap    = 1'b0;
        w_sel_ok = 1'b0;
        for (int i = 0; i < NTAP; i++) begin
            if (32'(r_sel_q) == i) begin
                w_tap    = r_s2[i];
                w_sel_ok = 1'b1;
            end
        end
    end

    assign w_rise = w_tap & ~r_prev;

    // Edge-detect history tracks the tap in every state so stale highs never tick
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prev    <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            r_prev    <= w_tap;
            r_sel_err <= ~w_sel_ok;
        end
    end

    // FSM state, latched selection, settle counter and registered tick
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= c_IDLE;
            r_sel_q  <= '0;
            r_settle <= '0;
            r_tick   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel_q  <= w_sel_nxt;
            r_settle <= w_settle_nxt;
            r_tick   <= w_tick_nxt;
        end
    end

    // Next-state: disable beats reselect, reselect restarts settling from any state
    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel_q;
        w_settle_nxt = r_settle;
        w_tick_nxt   = 1'b0;
        if (!en) begin
            w_state_nxt = c_IDLE;
        end else if ((sel != r_sel_q) || (r_state == c_IDLE)) begin
            w_sel_nxt    = sel;
            w_settle_nxt = c_SETTLE_LOAD;
            w_state_nxt  = c_SETTLE;
        end else if (r_state == c_SETTLE) begin
            if (r_settle == '0) begin
                w_state_nxt = c_RUN;
            end else begin
                w_settle_nxt = r_settle - c_SETTLE_ONE;
            end
        end else if (r_state == c_RUN) begin
            w_tick_nxt = w_rise & ~r_sel_err;
        end else begin
            w_state_nxt = c_IDLE;
        end
    end

    // Tick counter; clear has priority and never produces a wrap pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (r_tick) begin
            r_cnt  <= r_cnt + c_CNT_ONE;
            r_wrap <= &r_cnt;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign tick     = r_tick;
    assign tick_cnt = r_cnt;
    assign wrap     = r_wrap;
    assign sel_err  = r_sel_err;
    assign busy     = (r_state == c_SETTLE);

endmodule
`default_nettype wire

// File: tb/tb_div_tick_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_tick_sync
//  Description : Randomised self-checking bench for div_tick_sync against a
//                behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_tick_sync;

    localparam int NTAP       = 10;
    localparam int SEL_W      = 4;
    localparam int CNT_W      = 4;
    localparam int SETTLE_CYC = 4;
    localparam int NCYC       = 4000;

    logic             clk    = 1'b0;
    logic             rstn   = 1'b0;
    logic [NTAP-1:0]  div_in = '0;
    logic [SEL_W-1:0] sel    = '0;
    logic             en     = 1'b0;
    logic             clr    = 1'b0;
    logic             tick;
    logic [CNT_W-1:0] tick_cnt;
    logic             wrap;
    logic             sel_err;
    logic             busy;

    div_tick_sync #(
        .NTAP       (NTAP),
        .SEL_W      (SEL_W),
        .CNT_W      (CNT_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) u_dut (
        .clk      (clk),
        .rstn     (rstn),
        .div_in   (div_in),
        .sel      (sel),
        .en       (en),
        .clr      (clr),
        .tick     (tick),
        .tick_cnt (tick_cnt),
        .wrap     (wrap),
        .sel_err  (sel_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle, 1=settling, 2=running
    int              m_mode, m_sel, m_left, m_err, m_tick, m_cnt, m_wrap, m_prev;
    logic [NTAP-1:0] m_hist[$];

    task automatic model_reset();
        m_mode = 0; m_sel = 0; m_left = 0; m_err = 0;
        m_tick = 0; m_cnt = 0; m_wrap = 0; m_prev = 0;
        m_hist = {};
        m_hist.push_back('0);
        m_hist.push_back('0);
    endtask

    // One clock edge: taps seen by the edge detector are the samples from two edges ago
    task automatic model_step();
        logic [NTAP-1:0] seen;
        int tap, rise, err_new, tick_new;
        seen     = m_hist[0];
        tap      = (m_sel < NTAP) ? int'(seen[m_sel]) : 0;
        rise     = (tap == 1 && m_prev == 0) ? 1 : 0;
        err_new  = (m_sel >= NTAP) ? 1 : 0;
        tick_new = 0;
        if (clr) begin
            m_cnt = 0; m_wrap = 0;
        end else if (m_tick == 1) begin
            m_wrap = (m_cnt == (1 << CNT_W) - 1) ? 1 : 0;
            m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        end else begin
            m_wrap = 0;
        end
        if (!en) begin
            m_mode = 0;
        end else if (int'(sel) != m_sel || m_mode == 0) begin
            m_sel = int'(sel); m_left = SETTLE_CYC - 1; m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_left == 0) m_mode = 2;
            else m_left--;
        end else begin
            tick_new = (rise == 1 && m_err == 0) ? 1 : 0;
        end
        m_tick = tick_new;
        m_err  = err_new;
        m_prev = tap;
        void'(m_hist.pop_front());
        m_hist.push_back(div_in);
    endtask

    task automatic check_outputs();
        check("tick",     tick,     m_tick);
        check("tick_cnt", tick_cnt, m_cnt);
        check("wrap",     wrap,     m_wrap);
        check("sel_err",  sel_err,  m_err);
        check("busy",     busy,     (m_mode == 1) ? 1 : 0);
    endtask

    int half[NTAP];
    int ph[NTAP];

    initial begin
        model_reset();
        for (int i = 0; i < NTAP; i++) begin
            half[i] = $urandom_range(2, 8);
            ph[i]   = $urandom_range(0, half[i] - 1);
        end
        half[0] = 4;
        repeat (3) @(negedge clk);
        check_outputs();
        rstn = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            if (rstn) model_step();
            @(negedge clk);
            check_outputs();
            if (!rstn) rstn = 1'b1;

            // Square-wave taps, each with its own half-period
            for (int i = 0; i < NTAP; i++) begin
                ph[i]++;
                if (ph[i] >= half[i]) begin
                    ph[i]     = 0;
                    div_in[i] = ~div_in[i];
                end
            end

            clr = 1'b0;
            if (cyc == 10) en = 1'b1;
            if (cyc > 300) begin
                if ($urandom_range(0, 49) == 0)
                    sel = ($urandom_range(0, 3) == 0) ? SEL_W'($urandom_range(NTAP, 15))
                                                      : SEL_W'($urandom_range(0, NTAP - 1));
                if ($urandom_range(0, 149) == 0) en = ~en;
                if ($urandom_range(0, 39) == 0) clr = 1'b1;
                if ($urandom_range(0, 199) == 0) half[$urandom_range(0, NTAP - 1)] = $urandom_range(2, 8);
                if ($urandom_range(0, 499) == 0) begin
                    rstn = 1'b0;
                    #1;
                    model_reset();
                    check_outputs();
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
